// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: 32-step shift-add multiply and restoring divide, writing its result to a register file.
// Optional signed support is compiled in with the MULDIV_SIGNED_EN macro.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        sgn,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [4:0]  dst_addr,
  output logic        busy,
  output logic        done,
  output logic        reg_wr,
  output logic [4:0]  addr_wr,
  output logic [31:0] wr_data
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_e;

  localparam logic [5:0] LAST_ITER = 6'd32;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [1:0]  op_q;
  logic [4:0]  dst_q;
  logic [31:0] opnd_q;   // multiplicand (MUL) or divisor (DIV) magnitude
  logic [63:0] acc_q;    // {hi, lo}: product, or {remainder, quotient}
  logic        busy_q, done_q, reg_wr_q;
  logic [4:0]  addr_wr_q;
  logic [31:0] wr_data_q;

  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_fin;
  logic [31:0] quo_fin, rem_fin;

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_prod_d, neg_quo_d, neg_rem_d;
  logic neg_prod_q, neg_quo_q, neg_rem_q;

  always_comb begin
    a_neg      = sgn & src0[31];
    b_neg      = sgn & src1[31];
    a_mag      = a_neg ? (~src0 + 32'd1) : src0;
    b_mag      = b_neg ? (~src1 + 32'd1) : src1;
    neg_prod_d = a_neg ^ b_neg;
    // A zero divisor must leave the all-ones quotient uncorrected.
    neg_quo_d  = (a_neg ^ b_neg) & (src1 != 32'd0);
    neg_rem_d  = a_neg;
  end

  always_comb begin
    prod_fin = neg_prod_q ? (~acc_q + 64'd1) : acc_q;
    quo_fin  = neg_quo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fin  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_mag      = src0;
  assign b_mag      = src1;
  assign prod_fin   = acc_q;
  assign quo_fin    = acc_q[31:0];
  assign rem_fin    = acc_q[63:32];
`endif

  // One shift-add multiply step.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  // One restoring divide step; the trial difference is 34 bits so its sign is unambiguous.
  logic [64:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q, 1'b0};
    div_diff  = {1'b0, div_shift[64:32]} - {2'b00, opnd_q};
    div_next  = div_diff[33] ? {div_shift[63:32], acc_q[30:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
    unique case (op_q)
      2'b00:   result = prod_fin[31:0];
      2'b01:   result = prod_fin[63:32];
      2'b10:   result = quo_fin;
      default: result = rem_fin;
    endcase
  end

  // NOTE: all state, including the datapath, uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      reg_wr_q  <= 1'b0;
      addr_wr_q <= '0;
      wr_data_q <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            dst_q   <= dst_addr;
            cnt_q   <= '0;
            opnd_q  <= op[1] ? b_mag : a_mag;
            acc_q   <= {32'd0, op[1] ? a_mag : b_mag};
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef MULDIV_SIGNED_EN
            neg_prod_q <= neg_prod_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
`endif
          end
        end
        RUN: begin
          if (cnt_q == LAST_ITER) begin
            done_q    <= 1'b1;
            reg_wr_q  <= (dst_q != 5'd0);
            addr_wr_q <= dst_q;
            wr_data_q <= result;
            state_q   <= WRITE;
          end else begin
            acc_q <= op_q[1] ? div_next : mul_next;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        WRITE: begin
          done_q    <= 1'b0;
          reg_wr_q  <= 1'b0;
          addr_wr_q <= '0;
          wr_data_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign reg_wr  = reg_wr_q;
  assign addr_wr = addr_wr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; signed vectors run when MULDIV_SIGNED_EN is defined.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] src0 = '0;
  logic [31:0] src1 = '0;
  logic [4:0]  dst_addr = '0;
  logic        busy, done, reg_wr;
  logic [4:0]  addr_wr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sgn(sgn),
    .src0(src0), .src1(src1), .dst_addr(dst_addr),
    .busy(busy), .done(done), .reg_wr(reg_wr), .addr_wr(addr_wr), .wr_data(wr_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic run_op(input string tag, input logic [1:0] o, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                        input logic [31:0] exp, input int inject_at);
    int cnt;
    int extra;
    op = o; sgn = s; src0 = a; src1 = b; dst_addr = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src0 = $urandom; src1 = $urandom; op = ~o; dst_addr = ~d;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    cnt = 0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
      start = (inject_at >= 0 && cnt == inject_at);
    end
    start = 1'b0;
    check({tag, " latency"}, cnt, 32'd33);
    check({tag, " reg_wr"}, {31'd0, reg_wr}, {31'd0, d != 5'd0});
    check({tag, " addr_wr"}, {27'd0, addr_wr}, {27'd0, d});
    check({tag, " wr_data"}, wr_data, exp);
    @(negedge clk);
    check({tag, " done_pulse"}, {30'd0, done, reg_wr}, 32'd0);
    check({tag, " idle_out"}, wr_data | {27'd0, addr_wr} | {31'd0, busy}, 32'd0);
    if (inject_at >= 0) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) extra++;
      end
      check({tag, " extra_done"}, extra, 32'd0);
    end
  endtask

  task automatic reset_mid_run();
    int seen;
    op = 2'b00; sgn = 1'b0; src0 = 32'd5; src1 = 32'd5; dst_addr = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst outs", {30'd0, done, reg_wr} | wr_data | {27'd0, addr_wr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (reg_wr || done || busy) seen++;
    end
    check("rst no_write", seen, 32'd0);
  endtask

  initial begin
    #12;
    check("reset outs", {29'd0, busy, done, reg_wr} | wr_data | {27'd0, addr_wr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_lo 7*6",   2'b00, 1'b0, 32'd7, 32'd6, 5'd3, 32'd42, -1);
    run_op("mul_hi max",   2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE, -1);
    run_op("mul_lo max",   2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000001, -1);
    run_op("div 100/0",    2'b10, 1'b0, 32'd100, 32'd0, 5'd9, 32'hFFFFFFFF, -1);
    run_op("rem 100/0",    2'b11, 1'b0, 32'd100, 32'd0, 5'd9, 32'd100, -1);
    run_op("div 100/7",    2'b10, 1'b0, 32'd100, 32'd7, 5'd31, 32'd14, -1);
    run_op("rem 100/7",    2'b11, 1'b0, 32'd100, 32'd7, 5'd31, 32'd2, -1);
    run_op("dst0 ignore",  2'b00, 1'b0, 32'd3, 32'd4, 5'd0, 32'd12, 10);

    reset_mid_run();
    run_op("after rst",    2'b00, 1'b0, 32'd9, 32'd9, 5'd1, 32'd81, -1);

`ifdef MULDIV_SIGNED_EN
    run_op("s div -7/2",   2'b10, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, -1);
    run_op("s rem -7/2",   2'b11, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFF, -1);
    run_op("s mulh -3*5",  2'b01, 1'b1, 32'hFFFFFFFD, 32'd5, 5'd4, 32'hFFFFFFFF, -1);
    run_op("s div ovf",    2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h80000000, -1);
    run_op("s rem ovf",    2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'd0, -1);
    run_op("s div -100/0", 2'b10, 1'b1, 32'hFFFFFF9C, 32'd0, 5'd2, 32'hFFFFFFFF, -1);
    run_op("s rem -100/0", 2'b11, 1'b1, 32'hFFFFFF9C, 32'd0, 5'd2, 32'hFFFFFF9C, -1);
`else
    run_op("u div sgn1",   2'b10, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd4, 32'h7FFFFFFC, -1);
    run_op("u rem sgn1",   2'b11, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd4, 32'd1, -1);
    run_op("u mulh sgn1",  2'b01, 1'b1, 32'hFFFFFFFD, 32'd5, 5'd4, 32'd4, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
